wb_frame_reader: RTL

WB_FRAME_READER -- requirements
Module: wb_frame_reader

---
 rtl/wb_frame_reader_if.sv | 27 ++
 rtl/wb_frame_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_frame_reader_if.sv
// Wishbone B4 pipelined/classic bus bundle shared by the frame reader and its slave.
// Latency: none, wires only.
// Backpressure: carried by ack; the master waits for it on every beat.
//
// Signals: cyc/stb/we/adr/sel/cti/bte are driven by the master; dat_sm/ack are
// driven by the slave (dat_sm = slave-to-master read data).
interface wshb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, sel, cti, bte,
    input  dat_sm, ack
  );

  modport slave (
    input  cyc, stb, we, adr, sel, cti, bte,
    output dat_sm, ack
  );
endinterface

// File: rtl/wb_frame_reader.sv
// Reads a frame of NWORDS 32-bit words from Wishbone memory in bursts, repeating forever, into a FWFT FIFO.
// Latency: a word is visible on dout the cycle after its ack (registered FIFO write).
// Backpressure: a burst only starts when the FIFO can absorb BURST_LEN more words; dready stalls the FIFO head.
//
// Ports:
//   clk, rst      single clock; asynchronous active-high reset
//   wb_m          Wishbone master (read only: we=0, sel=F, bte=00)
//   enable        high: keep reading frames; sampled only between bursts
//   dout/dvalid   FIFO head (first-word-fall-through), dout=0 while empty
//   dready        consumer pops dout when dvalid&dready
//   frame_done    one-cycle pulse when the last word of a frame lands in the FIFO
//   fifo_level    current FIFO occupancy
//
// Build option: define WB_FRAME_READER_BURST_EN for incrementing bursts
// (cti=010 ... 111, stb held high). Without it every word is a classic cycle
// (cti=000) and stb drops for one cycle after each ack; cyc stays high for the
// whole group of up to BURST_LEN words either way.
module wb_frame_reader #(
  parameter logic [31:0] BASE_ADR   = 32'h0,
  parameter int          NWORDS     = 2048,
  parameter int          BURST_LEN  = 8,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  wshb_if.master                        wb_m,
  input  logic                          enable,
  output logic [31:0]                   dout,
  output logic                          dvalid,
  input  logic                          dready,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(NWORDS);
  localparam int BW = $clog2(BURST_LEN) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUS    = 2'd1;
  localparam logic [1:0] S_ENDCYC = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [IW-1:0] widx_q, widx_d;       // word index within the frame
  logic [BW-1:0] beats_q, beats_d;     // beats still to be acked in this burst
  logic          stb_q, stb_d;
  logic          frame_done_q, frame_done_d;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [LW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW:0]   level_q, level_d;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic          ack_ok;
  logic          push;
  logic          pop;
  logic          last_word;
  logic [IW:0]   words_rem;
  logic [BW-1:0] burst_len_w;
  logic [BW-1:0] inflight;
  logic [LW+1:0] space_w;
  logic          start_ok;

  // ack only counts while we are actually strobing a beat; stray acks are dropped
  assign ack_ok    = (state_q == S_BUS) && stb_q && wb_m.ack;
  assign push      = ack_ok;
  assign pop       = dvalid && dready;
  assign last_word = (widx_q == IW'(NWORDS - 1));

  // The final burst of a frame is shortened so it never runs past the frame end
  assign words_rem   = (IW+1)'(NWORDS) - {1'b0, widx_q};
  assign burst_len_w = (words_rem < (IW+1)'(BURST_LEN)) ? BW'(words_rem) : BW'(BURST_LEN);

  // Free space counts beats already promised to the bus. Always the full
  // BURST_LEN is reserved, even for a shortened last burst.
  assign inflight = (state_q == S_BUS) ? beats_q : '0;
  assign space_w  = (LW+2)'(FIFO_DEPTH) - {1'b0, level_q} - (LW+2)'(inflight);
  assign start_ok = enable && (space_w >= (LW+2)'(BURST_LEN));

  // ---------------------------------------------------------------------------
  // Bus FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    widx_d       = widx_q;
    beats_d      = beats_q;
    stb_d        = stb_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_BUS;
          beats_d = burst_len_w;
          stb_d   = 1'b1;
        end
      end

      S_BUS: begin
        if (ack_ok) begin
          // Address wraps to the frame start after the last word
          adr_d        = last_word ? BASE_ADR : adr_q + 32'd4;
          widx_d       = last_word ? '0 : widx_q + IW'(1);
          frame_done_d = last_word;
          beats_d      = beats_q - BW'(1);
          if (beats_q == BW'(1)) begin
            state_d = S_ENDCYC;
            stb_d   = 1'b0;
          end else begin
`ifdef WB_FRAME_READER_BURST_EN
            stb_d = 1'b1;
`else
            // classic cycle: one idle strobe cycle between words
            stb_d = 1'b0;
`endif
          end
        end else if (!stb_q) begin
          stb_d = 1'b1;
        end
      end

      S_ENDCYC: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      adr_q        <= BASE_ADR;
      widx_q       <= '0;
      beats_q      <= '0;
      stb_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      widx_q       <= widx_d;
      beats_q      <= beats_d;
      stb_q        <= stb_d;
      frame_done_q <= frame_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (LW+1)'(1);
      2'b01:   level_d = level_q - (LW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + LW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + LW'(1);
      level_q <= level_d;
    end
  end

  // Storage needs no reset: the level counter says what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wb_m.dat_sm;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dvalid     = (level_q != '0);
  assign dout       = dvalid ? mem[rd_ptr_q] : 32'h0;
  assign fifo_level = level_q;
  assign frame_done = frame_done_q;

  assign wb_m.cyc = (state_q == S_BUS);
  assign wb_m.stb = stb_q && (state_q == S_BUS);
  assign wb_m.we  = 1'b0;
  assign wb_m.sel = 4'hF;
  assign wb_m.bte = 2'b00;
  assign wb_m.adr = adr_q;
`ifdef WB_FRAME_READER_BURST_EN
  assign wb_m.cti = (state_q != S_BUS)  ? 3'b000 :
                    (beats_q == BW'(1)) ? 3'b111 : 3'b010;
`else
  assign wb_m.cti = 3'b000;
`endif

endmodule
